uart_tx_fifo: RTL
=================

# uart_tx_fifo

Transmit buffer between the processor's `UARTwr` path and the UART transmitter. Stores up to `fifoDepth` bytes written by the core. It raises `txStart` while data is pending and pops one byte on each transmitter read strobe, which is the transmitter's `txDoneTick`. The popped byte is held stable on `dout` for the whole frame, and status is exported for `UARTstat`.

## Interface
Parameters:
- `dataBits`, 8, byte width.
- `fifoDepth`, 16, number of entries; power of two.
- `fifoWidth`, 4, pointer width, log2(`fifoDepth`).
- `fifoCntrWidth`, 5, occupancy counter width, `fifoWidth`+1.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `wr`  in  1  Write strobe from the core; one byte per high cycle.
- `wrData`  in  `dataBits`  Byte to enqueue, sampled when `wr`=1.
- `rd`  in  1  Pop strobe; wired to the transmitter's `txDoneTick`.
- `dout`  out  `dataBits`  Last popped byte; drives the transmitter `din`.
- `txStart`  out  1  Data pending; high whenever the FIFO is not empty.
- `empty`  out  1  Occupancy is 0.
- `full`  out  1  Occupancy is `fifoDepth`.
- `count`  out  `fifoCntrWidth`  Current occupancy, 0..`fifoDepth`.
- `overflow`  out  1  Sticky flag: a write was dropped while full.
- `clrOvf`  in  1  Synchronous clear of `overflow`.

## Operation
- Storage is a circular buffer `mem[fifoDepth]`, with write pointer `wPtr` and read pointer `rPtr`, both `fifoWidth` bits.
- Pointers wrap naturally from `fifoDepth-1` to 0.
- **Accepted write** (`wr`=1 and (not full, or `rd` accepted in the same cycle)):
  - `mem[wPtr]` <= `wrData`.
  - `wPtr` <= `wPtr`+1.
- **Dropped write** (`wr`=1, full, no accepted `rd`):
  - memory and pointers are unchanged.
  - `overflow` <= 1.
- **Accepted read** (`rd`=1 and not empty):
  - `dout` <= `mem[rPtr]`.
  - `rPtr` <= `rPtr`+1.
- **`rd` while empty:** ignored. `dout`, pointers and `count` are unchanged. No error flag.
- **`count` update:**
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - unchanged when both, or neither, occur.
- **Flags:** `empty`, `full` and `count` are registered and updated on the same edge as the pointers.
  - `empty` = (`count`_next == 0).
  - `full` = (`count`_next == `fifoDepth`).
- **`txStart`** = ~`empty`, taken combinationally from the registered `empty`.
- **`dout` hold:** `dout` changes only on an accepted read. It stays stable until the next accepted read, so the transmitter may sample `din` at any time during its start state.
- **`overflow`:**
  - set by a dropped write.
  - cleared by `clrOvf`=1.
  - if a drop and `clrOvf` occur in the same cycle, set wins.
- **Simultaneous `wr` and `rd`:**
  - when full: both are accepted, `count` stays `fifoDepth`, no overflow.
  - when empty: the write is accepted, the read is ignored, and `count` becomes 1.
  - otherwise: both are accepted.

## Timing
- **Reset** (`reset`=0, asynchronous): `wPtr`=0, `rPtr`=0, `count`=0, `empty`=1, `full`=0, `txStart`=0, `dout`=0, `overflow`=0. Memory contents are not reset.
- Release of reset is synchronous to `clk`.
- **Write to `txStart` latency:** a write at edge N into an empty FIFO gives `empty`=0 and `txStart`=1 after edge N.
- **Read to `dout` latency:** an `rd` sampled at edge N presents the popped byte on `dout` after edge N.
- **Last-byte pop:** popping the last byte at edge N drops `txStart` after edge N. The transmitter therefore sees `txStart`=0 on return to idle unless new data was written.
- **Throughput:** one write and one read per cycle sustained.
- **Reset mid-frame:** all state clears immediately. `dout` goes to 0 and any pending bytes are discarded.

## Test plan
- **Reset:** hold `reset`=0, then release → `empty`=1, `txStart`=0, `count`=0, `dout`=0x00, `overflow`=0.
- **Ordering:**
  - write 0x55, 0xA3, 0x0F on consecutive cycles → `count`=3, `txStart`=1.
  - pulse `rd` three times → `dout` = 0x55, 0xA3, 0x0F in order, each held until the next `rd`.
  - after the third pop, `empty`=1 and `txStart`=0.
- **Fill, overflow and wrap:**
  - write 17 bytes 0x00..0x10 → `full`=1 after the 16th write, `count`=16; the 17th write sets `overflow`=1 and 0x10 is not stored.
  - drain 16 → `dout` sequence 0x00..0x0F.
  - write then read 20 more bytes → data stays correct across the pointer wrap.
- **Simultaneous events:**
  - full FIFO, `wr`=1 with 0x77 and `rd`=1 together → `count` stays 16, `overflow`=0, and 0x77 is read out last.
  - empty FIFO, `wr` and `rd` together → `count`=1 and `dout` unchanged.
- **Overflow control:**
  - full FIFO, `wr`=1 with `clrOvf`=1 in the same cycle → `overflow`=1 (set wins).
  - `clrOvf`=1 in the next cycle → `overflow`=0.
- **Integration with the transmitter:**
  - write 0xC5 → `txStart` rises.
  - the transmitter's `txDoneTick` pops it and `dout`=0xC5 for the whole frame.
  - the `tx` line carries start 0, data bits LSB first 1,0,1,0,0,0,1,1, stop 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that sits between the core's UARTwr path and
// the UART transmitter, with sticky overflow and occupancy status.
module uart_tx_fifo #(
    parameter int dataBits      = 8,
    parameter int fifoDepth     = 16,
    parameter int fifoWidth     = 4,
    parameter int fifoCntrWidth = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [dataBits-1:0]      wrData,
    input  logic                     rd,
    output logic [dataBits-1:0]      dout,
    output logic                     txStart,
    output logic                     empty,
    output logic                     full,
    output logic [fifoCntrWidth-1:0] count,
    output logic                     overflow,
    input  logic                     clrOvf
);

    logic [dataBits-1:0]      mem [fifoDepth];
    logic [fifoWidth-1:0]     wPtr;
    logic [fifoWidth-1:0]     rPtr;
    logic [fifoCntrWidth-1:0] countNext;
    logic                     rdAcc;
    logic                     wrAcc;
    logic                     wrDrop;

    localparam logic [fifoCntrWidth-1:0] cntOne  = fifoCntrWidth'(1);
    localparam logic [fifoCntrWidth-1:0] cntFull = fifoCntrWidth'(fifoDepth);

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the write.
    assign rdAcc  = rd & ~empty;
    assign wrAcc  = wr & (~full | rdAcc);
    assign wrDrop = wr & ~wrAcc;

    always_comb begin
        countNext = count;
        unique case ({wrAcc, rdAcc})
            2'b10:   countNext = count + cntOne;
            2'b01:   countNext = count - cntOne;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem[wPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wPtr     <= '0;
            rPtr     <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrAcc) begin
                wPtr <= wPtr + 1'b1;
            end
            if (rdAcc) begin
                dout <= mem[rPtr];
                rPtr <= rPtr + 1'b1;
            end
            count <= countNext;
            empty <= (countNext == '0);
            full  <= (countNext == cntFull);
            if (wrDrop) begin
                overflow <= 1'b1;
            end else if (clrOvf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign txStart = ~empty;

endmodule
